// File: rtl/alu_seq_unit_if.sv
// Request/response bundle for alu_seq_unit.
// The requester drives operands and the opcode and consumes the result;
// the unit drives the ready/valid returns, result, flags and busy.
interface alu_seq_unit_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in0;
  logic [N-1:0] in1;
  logic [2:0]   func3;
  logic         sub;
  logic         muldiv;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out;
  logic [3:0]   flags;
  logic         busy;

  modport master (
    output in_valid, in0, in1, func3, sub, muldiv, out_ready,
    input  in_ready, out_valid, out, flags, busy
  );

  modport slave (
    input  in_valid, in0, in1, func3, sub, muldiv, out_ready,
    output in_ready, out_valid, out, flags, busy
  );
endinterface

// File: rtl/alu_seq_unit.sv
// Handshaked RV32I/RV64I ALU with registered result and flags.
// Optional iterative M-extension engine (radix-2 shift-add multiply,
// restoring divide) is built only when ALU_MULDIV_EN is defined; without it
// M-extension requests return zero with the zero flag set.
// FLAGS = {overflow, negative, carry, zero}.
module alu_seq_unit #(
  parameter int N = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  alu_seq_unit_if.slave bus
);
  localparam int SHW = $clog2(N);
  localparam logic [N-1:0] MIN_NEG  = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ALL_ONES = {N{1'b1}};

  function automatic logic [N-1:0] cond_neg(input logic [N-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*N-1:0] cond_neg2(input logic [2*N-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [3:0] mk_flags(input logic [N-1:0] r, input logic c, input logic v);
    return {v, r[N-1], c, (r == '0)};
  endfunction

  logic [N-1:0] out_q, out_d;
  logic [3:0]   flags_q, flags_d;
  logic         out_valid_q, out_valid_d;
  logic         accept;

  logic                 sub_sel;
  logic [N-1:0]         add_b;
  logic [N:0]           sum;
  logic                 cout, c_msb, ovf, slt, sltu, cv_en;
  logic signed [N-1:0]  in0_s;
  logic [N-1:0]         sra_res;
  logic [SHW-1:0]       shamt;
  logic [N-1:0]         base_res;
  logic [N-1:0]         imm_res;
  logic [3:0]           imm_flags;

  assign accept = bus.in_valid && bus.in_ready;

  // SLT/SLTU share the subtractor with SUB; carry into the MSB is recovered
  // from the sum bit so one adder serves every compare and flag.
  assign sub_sel = (bus.func3 == 3'b000) ? bus.sub
                                         : ((bus.func3 == 3'b010) || (bus.func3 == 3'b011));
  assign add_b   = sub_sel ? ~bus.in1 : bus.in1;
  assign sum     = {1'b0, bus.in0} + {1'b0, add_b} + {{N{1'b0}}, sub_sel};
  assign cout    = sum[N];
  assign c_msb   = sum[N-1] ^ bus.in0[N-1] ^ add_b[N-1];
  assign ovf     = cout ^ c_msb;
  assign slt     = sum[N-1] ^ ovf;
  assign sltu    = ~cout;
  assign cv_en   = (bus.func3 == 3'b000);
  assign in0_s   = bus.in0;
  assign sra_res = in0_s >>> shamt;
  assign shamt   = bus.in1[SHW-1:0];

  // Base-op result for the current request
  always_comb begin
    base_res = '0;
    unique case (bus.func3)
      3'b000:  base_res = sum[N-1:0];
      3'b001:  base_res = bus.in0 << shamt;
      3'b010:  base_res = {{(N-1){1'b0}}, slt};
      3'b011:  base_res = {{(N-1){1'b0}}, sltu};
      3'b100:  base_res = bus.in0 ^ bus.in1;
      3'b101:  base_res = bus.sub ? sra_res : (bus.in0 >> shamt);
      3'b110:  base_res = bus.in0 | bus.in1;
      default: base_res = bus.in0 & bus.in1;
    endcase
  end

`ifdef ALU_MULDIV_EN
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [2*N-1:0]   acc_q, acc_d;
  logic [N-1:0]     opa_q, opa_d;
  logic [N-1:0]     opb_q, opb_d;
  logic             neg_q, neg_d;
  logic [2:0]       op_q, op_d;

  logic             is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic             div_zero, div_ovf, div_special, start_eng;
  logic [N-1:0]     a_mag, b_mag, div_sp_res, fix_res;
  logic [N:0]       mul_sum, div_shift, div_trial;
  logic             div_qbit;
  logic [N-1:0]     div_rem;
  logic [2*N-1:0]   prod;

  // Operand signedness: DIV/REM and MULH/MULHSU treat rs1 as signed.
  assign is_div = bus.func3[2];
  assign a_sgn  = is_div ? ~bus.func3[0] : ((bus.func3[1:0] == 2'b01) || (bus.func3[1:0] == 2'b10));
  assign b_sgn  = is_div ? ~bus.func3[0] : (bus.func3[1:0] == 2'b01);
  assign a_neg  = a_sgn & bus.in0[N-1];
  assign b_neg  = b_sgn & bus.in1[N-1];
  assign a_mag  = cond_neg(bus.in0, a_neg);
  assign b_mag  = cond_neg(bus.in1, b_neg);

  // Divide-by-zero and MIN/-1 skip the engine and finish like a base op.
  assign div_zero    = (bus.in1 == '0);
  assign div_ovf     = ~bus.func3[0] && (bus.in0 == MIN_NEG) && (bus.in1 == ALL_ONES);
  assign div_special = div_zero || div_ovf;
  assign div_sp_res  = bus.func3[1] ? (div_zero ? bus.in0 : '0)
                                    : (div_zero ? ALL_ONES : MIN_NEG);
  assign start_eng   = bus.muldiv && !(is_div && div_special);

  // Shift-add step: add multiplicand into the high half, shift the pair right.
  assign mul_sum   = {1'b0, acc_q[2*N-1:N]} + (opa_q[0] ? {1'b0, opb_q} : '0);
  // Restoring step: shift next dividend bit into the remainder, try to subtract.
  assign div_shift = {acc_q[2*N-1:N], opa_q[N-1]};
  assign div_trial = div_shift - {1'b0, opb_q};
  assign div_qbit  = ~div_trial[N];
  assign div_rem   = div_qbit ? div_trial[N-1:0] : div_shift[N-1:0];

  // Sign correction and result selection in FIX
  assign prod    = cond_neg2(acc_q, neg_q);
  assign fix_res = op_q[2] ? cond_neg(op_q[1] ? acc_q[2*N-1:N] : acc_q[N-1:0], neg_q)
                           : ((op_q[1:0] == 2'b00) ? prod[N-1:0] : prod[2*N-1:N]);

  assign bus.in_ready = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
  assign bus.busy     = (state_q != IDLE);
`else
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign bus.busy     = 1'b0;
`endif

  // Result and flags loaded on the accept edge when no iteration is needed
  always_comb begin
    imm_res   = base_res;
    imm_flags = mk_flags(base_res, cv_en & cout, cv_en & ovf);
    if (bus.muldiv) begin
`ifdef ALU_MULDIV_EN
      imm_res   = div_sp_res;
      imm_flags = mk_flags(div_sp_res, 1'b0, 1'b0);
`else
      imm_res   = '0;
      imm_flags = 4'b0001;
`endif
    end
  end

`ifdef ALU_MULDIV_EN
  // Next-state: accept, engine iterations, and sign fix-up
  always_comb begin
    out_d       = out_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    neg_d       = neg_q;
    op_d        = op_q;
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (start_eng) begin
            state_d = is_div ? DIV : MUL;
            cnt_d   = '0;
            acc_d   = '0;
            opa_d   = is_div ? a_mag : b_mag;
            opb_d   = is_div ? b_mag : a_mag;
            neg_d   = (is_div && bus.func3[1]) ? a_neg : (a_neg ^ b_neg);
            op_d    = bus.func3;
          end else begin
            out_d       = imm_res;
            flags_d     = imm_flags;
            out_valid_d = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d = {mul_sum, acc_q[N-1:1]};
        opa_d = opa_q >> 1;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == SHW'(N-1)) state_d = FIX;
      end
      DIV: begin
        acc_d = {div_rem, acc_q[N-2:0], div_qbit};
        opa_d = opa_q << 1;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == SHW'(N-1)) state_d = FIX;
      end
      FIX: begin
        out_d       = fix_res;
        flags_d     = mk_flags(fix_res, 1'b0, 1'b0);
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Engine control state; reset aborts any iteration in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Engine datapath registers, only meaningful while MUL/DIV/FIX
  always_ff @(posedge clk_i) begin
    acc_q <= acc_d;
    opa_q <= opa_d;
    opb_q <= opb_d;
    neg_q <= neg_d;
    op_q  <= op_d;
  end
`else
  // Next-state: every request completes on its accept edge
  always_comb begin
    out_d       = out_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
    if (accept) begin
      out_d       = imm_res;
      flags_d     = imm_flags;
      out_valid_d = 1'b1;
    end
  end
`endif

  // Output registers; held while the consumer stalls
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      flags_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.flags     = flags_q;
endmodule
